// File: rtl/baud_gen_nco.sv
// Fractional baud generator: a phase accumulator produces the oversample tick,
// and a ratio counter divides it into mid-bit and end-of-bit ticks.
module baud_gen_nco #(
    parameter int                   ACC_WIDTH        = 32,
    parameter int                   OVS_LOG2_MAX     = 4,
    parameter logic [ACC_WIDTH-1:0] DEFAULT_INC      = ACC_WIDTH'(79164837),
    parameter logic [2:0]           DEFAULT_OVS_LOG2 = 3'd4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 resync,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [ACC_WIDTH-1:0] cfg_inc,
    input  logic [2:0]           cfg_ovs_log2,
    output logic                 tick_ovs,
    output logic                 mid_tick,
    output logic                 baud_tick
);

    localparam int                   CNT_W   = OVS_LOG2_MAX;
    localparam logic [ACC_WIDTH-1:0] INC_MAX = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [2:0]           OVS_MAX = 3'(OVS_LOG2_MAX);

    typedef enum logic {
        ST_IDLE,
        ST_PENDING
    } cfg_state_t;

    cfg_state_t           state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]     ovs_cnt_q, ovs_cnt_d;
    logic [ACC_WIDTH-1:0] active_inc_q, active_inc_d;
    logic [2:0]           active_ovs_q, active_ovs_d;
    logic [ACC_WIDTH-1:0] shadow_inc_q, shadow_inc_d;
    logic [2:0]           shadow_ovs_q, shadow_ovs_d;
    logic                 tick_q, tick_d;
    logic                 mid_q, mid_d;
    logic                 baud_q, baud_d;

    logic [ACC_WIDTH:0]   sum;
    logic                 carry;
    logic                 run;
    logic                 transfer;
    logic                 apply;
    logic [ACC_WIDTH-1:0] inc_clamped;
    logic [2:0]           ovs_clamped;

    logic [OVS_LOG2_MAX:0] last_hit_vec;
    logic [OVS_LOG2_MAX:0] mid_hit_vec;
    logic                  cnt_is_last;
    logic                  cnt_is_mid;

    // One decoder per legal exponent; only the active one can match.
    // With OVS = 1 the mid point coincides with the bit end.
    generate
        for (genvar gi = 0; gi <= OVS_LOG2_MAX; gi++) begin : g_ovs_dec
            assign last_hit_vec[gi] = (active_ovs_q == 3'(gi)) &&
                                      (ovs_cnt_q == CNT_W'((1 << gi) - 1));
            if (gi == 0) begin : g_mid_one
                assign mid_hit_vec[gi] = last_hit_vec[gi];
            end else begin : g_mid_half
                assign mid_hit_vec[gi] = (active_ovs_q == 3'(gi)) &&
                                         (ovs_cnt_q == CNT_W'((1 << (gi - 1)) - 1));
            end
        end
    endgenerate

    assign cnt_is_last = |last_hit_vec;
    assign cnt_is_mid  = |mid_hit_vec;

    assign sum   = {1'b0, acc_q} + {1'b0, active_inc_q};
    assign carry = sum[ACC_WIDTH];
    assign run   = enable & ~resync;

    assign inc_clamped = (cfg_inc > INC_MAX) ? INC_MAX : cfg_inc;
    assign ovs_clamped = (cfg_ovs_log2 > OVS_MAX) ? OVS_MAX : cfg_ovs_log2;

    assign tick_d = run & carry;
    assign baud_d = tick_d & cnt_is_last;
    assign mid_d  = tick_d & cnt_is_mid;

    always_comb begin
        state_d  = state_q;
        transfer = 1'b0;
        apply    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    transfer = 1'b1;
                    state_d  = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (baud_d || !enable || resync) begin
                    apply   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        acc_d        = acc_q;
        ovs_cnt_d    = ovs_cnt_q;
        active_inc_d = active_inc_q;
        active_ovs_d = active_ovs_q;
        shadow_inc_d = shadow_inc_q;
        shadow_ovs_d = shadow_ovs_q;

        if (!run) begin
            acc_d     = '0;
            ovs_cnt_d = '0;
        end else begin
            acc_d = sum[ACC_WIDTH-1:0];
            if (carry) begin
                ovs_cnt_d = cnt_is_last ? '0 : ovs_cnt_q + 1'b1;
            end
        end

        // A bit-boundary apply keeps the accumulator so the phase stays continuous.
        if (apply) begin
            active_inc_d = shadow_inc_q;
            active_ovs_d = shadow_ovs_q;
            ovs_cnt_d    = '0;
        end

        if (transfer) begin
            shadow_inc_d = inc_clamped;
            shadow_ovs_d = ovs_clamped;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            ovs_cnt_q    <= '0;
            active_inc_q <= DEFAULT_INC;
            active_ovs_q <= DEFAULT_OVS_LOG2;
            shadow_inc_q <= DEFAULT_INC;
            shadow_ovs_q <= DEFAULT_OVS_LOG2;
            tick_q       <= 1'b0;
            mid_q        <= 1'b0;
            baud_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            ovs_cnt_q    <= ovs_cnt_d;
            active_inc_q <= active_inc_d;
            active_ovs_q <= active_ovs_d;
            shadow_inc_q <= shadow_inc_d;
            shadow_ovs_q <= shadow_ovs_d;
            tick_q       <= tick_d;
            mid_q        <= mid_d;
            baud_q       <= baud_d;
        end
    end

    assign cfg_ready = (state_q == ST_IDLE);
    assign tick_ovs  = tick_q;
    assign mid_tick  = mid_q;
    assign baud_tick = baud_q;

endmodule

// File: doc/baud_gen_nco.md
# baud_gen_nco

Runtime-programmable fractional baud generator for the UART. It is the successor to the fixed-parameter baud generator. A phase accumulator (NCO) produces an oversample tick. A programmable-ratio counter divides that tick down to bit-rate and mid-bit ticks. Rate and oversampling factor are changed through a valid/ready config port and applied glitch-free at the next bit boundary. A `resync` input realigns the phase to an RX start-bit edge. The block sits between the register interface and the UART TX/RX engines.

## Interface
- `ACC_WIDTH`, 32: accumulator fraction bits; the increment is `round(2^ACC_WIDTH * BAUD * OVS / CLK_FREQ)`
- `OVS_LOG2_MAX`, 4: largest oversample exponent; OVS = 2^n with n in 0..OVS_LOG2_MAX
- `DEFAULT_INC`, 79164837: increment after reset (115200 baud, 16x, 100 MHz)
- `DEFAULT_OVS_LOG2`, 4: oversample exponent after reset
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `enable`  in  1  run the generator; when low, phase is held at zero
- `resync`  in  1  one-cycle pulse; restart bit phase (RX start-bit falling edge)
- `cfg_valid`  in  1  config offer
- `cfg_ready`  out  1  config can be accepted
- `cfg_inc`  in  ACC_WIDTH  new increment
- `cfg_ovs_log2`  in  3  new oversample exponent
- `tick_ovs`  out  1  oversample tick, one-cycle pulse
- `mid_tick`  out  1  mid-bit sample point, one-cycle pulse
- `baud_tick`  out  1  end of bit period, one-cycle pulse

## Operation
- State:
  - `acc` (ACC_WIDTH)
  - `ovs_cnt` (OVS_LOG2_MAX bits)
  - `active_inc`, `active_ovs`
  - `shadow_inc`, `shadow_ovs`
  - `pending`
- Accumulator, each enabled cycle without `resync`:
  - `sum = {1'b0, acc} + active_inc`
  - `acc <= sum[ACC_WIDTH-1:0]`
  - `carry = sum[ACC_WIDTH]`
- Register each output from the same-cycle `carry`:
  - `tick_ovs <= carry`
  - `mid_tick <= carry & (ovs_cnt == OVS/2 - 1)`; when OVS = 1, `mid_tick` follows `baud_tick`
  - `baud_tick <= carry & (ovs_cnt == OVS - 1)`
- On `carry`, `ovs_cnt` increments, or wraps to 0 when it equals OVS-1.
- Clamping:
  - `cfg_inc` above 2^(ACC_WIDTH-1) is stored as 2^(ACC_WIDTH-1), so the minimum tick spacing is 2 cycles.
  - `cfg_inc` = 0 is legal and stops all ticks.
  - `cfg_ovs_log2` above OVS_LOG2_MAX is stored as OVS_LOG2_MAX.
- Config handshake:
  - `cfg_ready = !pending`.
  - Transfer occurs on `cfg_valid & cfg_ready`: capture into shadow (after clamping) and set `pending`.
- Apply rule: when `pending` and any of the following hold, copy shadow to active, clear `ovs_cnt`, and clear `pending`:
  - (a) the cycle where `baud_tick` is being set
  - (b) `enable` low
  - (c) `resync` high
  - On an apply, `acc` is cleared only for (b) and (c).
- `resync` (only while `enable` is high):
  - clears `acc` and `ovs_cnt`
  - suppresses that cycle's carry (no ticks next cycle)
  - takes priority over carry
- `enable` low:
  - `acc` = 0 and `ovs_cnt` = 0
  - all ticks deasserted the next cycle
  - config still accepted, and applied the following cycle
- There are no other states. `pending` is the only control FSM: IDLE (ready) -> PENDING on transfer -> IDLE on apply.

## Timing
- Reset (asynchronous assert, synchronous-edge release):
  - `acc` = 0, `ovs_cnt` = 0, `pending` = 0
  - active = DEFAULT_*
  - all ticks 0, `cfg_ready` = 1
- Reset mid-operation or mid-pending discards the shadow.
- Tick latency: the first `tick_ovs` after `enable` rises occurs `ceil(2^ACC_WIDTH / inc) + 1` cycles after the first enabled edge (register stage +1).
- `tick_ovs`, `mid_tick` and `baud_tick` are mutually cycle-aligned; `mid_tick` and `baud_tick` only ever assert with `tick_ovs`.
- New config takes effect from the cycle after the `baud_tick` edge. The bit containing the transfer finishes at the old rate.
- `cfg_ready` falls the cycle after transfer. It rises the cycle after apply.
- Long-run tick rate equals `inc / 2^ACC_WIDTH` exactly. Tick-spacing jitter is at most 1 cycle.

## Test plan
- ACC_WIDTH=8, inc=64, ovs_log2=2, enable held:
  - `tick_ovs` every 4 cycles
  - `mid_tick` every 16 cycles, on the 2nd tick of each bit
  - `baud_tick` every 16 cycles, on the 4th tick
- ACC_WIDTH=8, inc=96: `tick_ovs` spacing repeats 3,3,2; exactly 3 ticks per 8 cycles over 800 cycles.
- Config while running:
  - Setup: inc=64, OVS=4; offer inc=32, ovs_log2=1 mid-bit.
  - `cfg_ready` is low until the next `baud_tick`.
  - After it, ticks come every 8 cycles and `baud_tick` every 16 cycles, with no partial bit.
- Clamp: `cfg_inc`=200 with enable low; after enable, `tick_ovs` every 2 cycles. `cfg_ovs_log2`=7 behaves as 4.
- `resync` at an arbitrary phase:
  - no tick in the following cycle
  - then `mid_tick` exactly 2*4+... i.e. OVS/2 ticks later (inc=64, OVS=4: 8 cycles + 1 latency)
  - `resync` coincident with a carry suppresses that tick.
- Async `reset_n` pulse mid-bit with a config pending: outputs drop to 0 immediately, `cfg_ready`=1, and DEFAULT rates resume after release.
